// File: rtl/great_add_sub.sv
// great_add_sub: word-serial big-number add/subtract, LSW first, with a borrow/carry flag on the MSW.
// Define GREAT_ADD_SUB_ABS_RESULT_EN to emit |A-B| in subtract mode (buffer + replay FSM).
module great_add_sub #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] a_in,
  input  logic [REGISTER_SIZE-1:0] b_in,
  input  logic                     sub_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out,
  output logic                     flag_out
);
  localparam int W = REGISTER_SIZE;
  localparam int NUM_WORDS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, mode_q, mode_d;
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, final_q, final_d, flag_q, flag_d;
  logic first, last, mode_w, cin, acc;
  logic [W-1:0] bb;
  logic [W:0] sum;
  assign first = cnt_q == '0;
  assign last = cnt_q == CW'(NUM_WORDS - 1);
  assign mode_w = first ? sub_in : mode_q;
  assign cin = first ? sub_in : carry_q;
  assign bb = mode_w ? ~b_in : b_in;
  assign sum = {1'b0, a_in} + {1'b0, bb} + (W+1)'(cin);
  assign acc = valid_in && ready_out;
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign final_out = final_q;
  assign flag_out = flag_q;
`ifdef GREAT_ADD_SUB_ABS_RESULT_EN
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] buf_q [NUM_WORDS];
  logic [CW-1:0] idx_q, idx_d;
  logic neg_q, neg_d, nc_q, nc_d, drain_q, drain_d;
  logic [W-1:0] rw;
  logic [W:0] neg_sum;
  assign rw = buf_q[idx_q];
  assign neg_sum = {1'b0, ~rw} + (W+1)'(nc_q);
  // drain_q keeps ready low during the cycle final_out is shown
  assign ready_out = state_q == IDLE && !drain_q;
`else
  assign ready_out = 1'b1;
`endif
  always_comb begin
    cnt_d = cnt_q;
    carry_d = carry_q;
    mode_d = mode_q;
    data_d = data_q;
    valid_d = 1'b0;
    final_d = 1'b0;
    flag_d = 1'b0;
`ifdef GREAT_ADD_SUB_ABS_RESULT_EN
    state_d = state_q;
    idx_d = idx_q;
    neg_d = neg_q;
    nc_d = nc_q;
    drain_d = 1'b0;
    if (state_q == EMIT) begin
      data_d = neg_q ? neg_sum[W-1:0] : rw;
      nc_d = neg_sum[W];
      valid_d = 1'b1;
      final_d = idx_q == CW'(NUM_WORDS - 1);
      flag_d = final_d & neg_q;
      idx_d = final_d ? '0 : idx_q + CW'(1);
      state_d = final_d ? IDLE : EMIT;
      drain_d = final_d;
    end
`endif
    if (acc) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      carry_d = sum[W];
      mode_d = mode_w;
`ifdef GREAT_ADD_SUB_ABS_RESULT_EN
      if (mode_w && last) begin
        state_d = EMIT;
        neg_d = ~sum[W];
        nc_d = 1'b1;
        idx_d = '0;
      end
      if (!mode_w) begin
`endif
      data_d = sum[W-1:0];
      valid_d = 1'b1;
      final_d = last;
      flag_d = last & (mode_w ? ~sum[W] : sum[W]);
`ifdef GREAT_ADD_SUB_ABS_RESULT_EN
      end
`endif
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      carry_q <= 1'b0;
      mode_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      final_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      mode_q <= mode_d;
      data_q <= data_d;
      valid_q <= valid_d;
      final_q <= final_d;
      flag_q <= flag_d;
    end
  end
`ifdef GREAT_ADD_SUB_ABS_RESULT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q <= '0;
      neg_q <= 1'b0;
      nc_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      neg_q <= neg_d;
      nc_q <= nc_d;
      drain_q <= drain_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in && acc && mode_w) buf_q[cnt_q] <= sum[W-1:0];
  end
`endif
endmodule

// File: tb/tb_great_add_sub.sv
// tb_great_add_sub: scoreboard bench for great_add_sub with 8-bit words, 32-bit numbers.
module tb_great_add_sub;
  logic clk_in = 1'b0;
  logic rst_in, sub_in, valid_in, ready_out, valid_out, final_out, flag_out;
  logic [7:0] a_in, b_in, data_out;
  typedef struct { logic [7:0] d; logic f; logic fl; } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  great_add_sub #(.REGISTER_SIZE(8), .BITS_IN_NUM(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in), .sub_in(sub_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .final_out(final_out), .flag_out(flag_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && valid_out) begin
      exp_t e;
      chk("unexpected_output", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("data", 32'(data_out), 32'(e.d));
        chk("final", 32'(final_out), 32'(e.f));
        if (e.f) chk("flag", 32'(flag_out), 32'(e.fl));
      end
    end else if (!rst_in && final_out) begin
      chk("final_without_valid", 32'(final_out), 32'd0);
    end
  end

  task automatic num(input logic [31:0] a, input logic [31:0] b, input logic sub, input int gap);
    logic [32:0] r;
    logic fl;
    r = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    fl = sub ? (a < b) : r[32];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      a_in = a[8*i +: 8];
      b_in = b[8*i +: 8];
      sub_in = i == 0 ? sub : 1'($urandom);
      valid_in = 1'b1;
      q.push_back('{r[8*i +: 8], i == 3, i == 3 && fl});
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk_in); #1;
          valid_in = 1'b0;
          a_in = 8'($urandom);
          b_in = 8'($urandom);
          sub_in = 1'($urandom);
          if (g > 0) begin
            @(negedge clk_in);
            chk("gap_valid", 32'(valid_out), 32'd0);
            chk("gap_hold", 32'(data_out), 32'(r[15:8]));
          end
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk_in);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_final"}, 32'(final_out), 32'd0);
    chk({tag, "_flag"}, 32'(flag_out), 32'd0);
    chk({tag, "_ready"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    valid_in = 1'b0;
    sub_in = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk_reset("reset");
    num(32'h00000105, 32'h00000003, 1'b1, 0);
    idle();
    num(32'h00000003, 32'h00000005, 1'b1, 0);
    idle();
    num(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    idle();
    num(32'h00000010, 32'h00000001, 1'b1, 0);
    num(32'h00000001, 32'h00000001, 1'b0, 0);
    idle();
    num(32'h00FF00FF, 32'h00010001, 1'b0, 3);
    idle();
    @(posedge clk_in); #1;
    a_in = 8'h44; b_in = 8'h01; sub_in = 1'b0; valid_in = 1'b1;
    q.push_back('{8'h45, 1'b0, 1'b0});
    @(posedge clk_in); #1;
    a_in = 8'h33; b_in = 8'h01; sub_in = 1'b1;
    q.push_back('{8'h34, 1'b0, 1'b0});
    idle();
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    chk_reset("abort");
    num(32'h00000009, 32'h00000004, 1'b1, 0);
    idle();
    repeat (4) @(negedge clk_in);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
